// File: rtl/pipe_ctrl_if.sv
// Stage-control bundle between the MIPS datapath and its pipeline sequencing controller.
// The datapath is the master (drives stage-resident fields); the controller is the slave.
interface pipe_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        br_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        halt_req;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        halt_ack;
  logic        mem_timeout;
  logic [15:0] stall_cnt;

  modport master (
    output id_rs, id_rt, ex_memread, ex_rt, br_taken, mem_req, mem_ready, halt_req,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           halt_ack, mem_timeout, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, ex_memread, ex_rt, br_taken, mem_req, mem_ready, halt_req,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           halt_ack, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use stall, branch flush, memory-wait freeze,
// post-reset bubble fill and debug halt/drain for the 5-stage MIPS core.
module pipe_ctrl #(
  parameter int unsigned INIT_CYC  = 4,
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned MAX_WAIT  = 15
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);
  localparam int unsigned IW = (INIT_CYC  > 1) ? $clog2(INIT_CYC)  : 1;
  localparam int unsigned DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam int unsigned SW = 16;

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN, ST_HALTED} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_timeout_q, mem_timeout_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;

  logic freeze, branch, hazard;
  logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
  logic ifid_flush_c, idex_flush_c;

  // Conditions in priority order: memory freeze, taken branch, load-use hazard.
  always_comb begin
    freeze = bus.mem_req & ~bus.mem_ready;
    branch = bus.br_taken;
    hazard = bus.ex_memread & (bus.ex_rt != 5'd0) &
             ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= '0;
      drain_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    stall_cnt_d   = stall_cnt_q;
    pc_en_c       = 1'b0;
    ifid_en_c     = 1'b0;
    idex_en_c     = 1'b0;
    exmem_en_c    = 1'b0;
    memwb_en_c    = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;

    case (state_q)
      ST_INIT: begin
        ifid_en_c    = 1'b1;
        idex_en_c    = 1'b1;
        exmem_en_c   = 1'b1;
        memwb_en_c   = 1'b1;
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
        if (init_cnt_q == IW'(INIT_CYC - 1)) begin
          init_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + IW'(1);
        end
      end

      ST_RUN, ST_DRAIN: begin
        if (freeze) begin
          // whole pipe frozen; all enables stay at their 0 defaults
        end else if (branch) begin
          pc_en_c      = 1'b1;
          ifid_en_c    = 1'b1;
          idex_en_c    = 1'b1;
          exmem_en_c   = 1'b1;
          memwb_en_c   = 1'b1;
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
        end else if (hazard) begin
          idex_en_c    = 1'b1;
          idex_flush_c = 1'b1;
          exmem_en_c   = 1'b1;
          memwb_en_c   = 1'b1;
        end else begin
          pc_en_c      = (state_q == ST_RUN);
          ifid_en_c    = 1'b1;
          idex_en_c    = 1'b1;
          exmem_en_c   = 1'b1;
          memwb_en_c   = 1'b1;
          ifid_flush_c = (state_q == ST_DRAIN);
        end

        // Consecutive-freeze watchdog; the error bit is sticky until reset.
        if (freeze) begin
          if (wait_cnt_q == WW'(MAX_WAIT)) begin
            wait_cnt_d    = wait_cnt_q;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WW'(1);
          end
        end

        if (state_q == ST_RUN) begin
          if (!pc_en_c && (stall_cnt_q != {SW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + SW'(1);
          end
          if (bus.halt_req && !freeze && !branch) begin
            drain_cnt_d = '0;
            state_d     = ST_DRAIN;
          end
        end else if (!freeze && !(hazard && !branch)) begin
          if (drain_cnt_q == DW'(DRAIN_CYC - 1)) begin
            drain_cnt_d = '0;
            state_d     = ST_HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q + DW'(1);
          end
        end
      end

      ST_HALTED: begin
        if (!bus.halt_req) begin
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  assign bus.pc_en       = pc_en_c;
  assign bus.ifid_en     = ifid_en_c;
  assign bus.idex_en     = idex_en_c;
  assign bus.exmem_en    = exmem_en_c;
  assign bus.memwb_en    = memwb_en_c;
  assign bus.ifid_flush  = ifid_flush_c;
  assign bus.idex_flush  = idex_flush_c;
  assign bus.halt_ack    = (state_q == ST_HALTED);
  assign bus.mem_timeout = mem_timeout_q;
  assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios then random traffic, all checked against
// a cycle-level behavioural model of the sequencing rules.
module tb_pipe_ctrl;
  localparam int unsigned INIT_CYC  = 4;
  localparam int unsigned DRAIN_CYC = 4;
  localparam int unsigned MAX_WAIT  = 15;

  logic clk = 1'b0;
  logic rst;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.INIT_CYC(INIT_CYC), .DRAIN_CYC(DRAIN_CYC), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int         m_init_done;
  bit         m_draining;
  bit         m_halted;
  int         m_drain_adv;
  int         m_freeze_run;
  bit         m_timeout;
  int         m_stalls;
  logic [7:0] m_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, halt_ack}
  function automatic logic [7:0] predict();
    bit frz, br, lu;
    frz = bus.mem_req && !bus.mem_ready;
    br  = bus.br_taken;
    lu  = bus.ex_memread && (bus.ex_rt != 0) &&
          ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));
    if (m_init_done < int'(INIT_CYC)) return 8'b0111_1110;
    if (m_halted)                     return 8'b0000_0001;
    if (frz)                          return 8'b0000_0000;
    if (br)                           return 8'b1111_1110;
    if (lu)                           return 8'b0011_1010;
    if (m_draining)                   return 8'b0111_1100;
    return 8'b1111_1000;
  endfunction

  task automatic model_reset();
    m_init_done  = 0;
    m_draining   = 0;
    m_halted     = 0;
    m_drain_adv  = 0;
    m_freeze_run = 0;
    m_timeout    = 0;
    m_stalls     = 0;
  endtask

  // Advance the model across one rising edge, given the outputs predicted for that cycle.
  task automatic model_edge(input logic [7:0] e);
    bit frz, br, lu;
    frz = bus.mem_req && !bus.mem_ready;
    br  = bus.br_taken;
    lu  = bus.ex_memread && (bus.ex_rt != 0) &&
          ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));
    if (m_init_done < int'(INIT_CYC)) begin
      m_init_done++;
      m_freeze_run = 0;
    end else if (m_halted) begin
      m_freeze_run = 0;
      if (!bus.halt_req) m_halted = 0;
    end else begin
      if (frz) begin
        if (m_freeze_run == int'(MAX_WAIT)) m_timeout = 1;
        else m_freeze_run++;
      end else begin
        m_freeze_run = 0;
      end
      if (!m_draining) begin
        if (!e[7] && m_stalls < 65535) m_stalls++;
        if (bus.halt_req && !frz && !br) begin
          m_draining  = 1;
          m_drain_adv = 0;
        end
      end else if (!frz && !(lu && !br)) begin
        m_drain_adv++;
        if (m_drain_adv == int'(DRAIN_CYC)) begin
          m_draining = 0;
          m_halted   = 1;
        end
      end
    end
  endtask

  task automatic check_now();
    m_exp = predict();
    chk("ctrl", 32'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                     bus.ifid_flush, bus.idex_flush, bus.halt_ack}), 32'(m_exp));
    chk("mem_timeout", 32'(bus.mem_timeout), 32'(m_timeout));
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stalls));
  endtask

  // One clock: check mid-cycle, then advance the model on the edge.
  task automatic step();
    @(negedge clk);
    check_now();
    @(posedge clk);
    if (rst) model_edge(m_exp);
    #1;
  endtask

  task automatic idle();
    bus.id_rs      = 5'd0;
    bus.id_rt      = 5'd0;
    bus.ex_memread = 1'b0;
    bus.ex_rt      = 5'd0;
    bus.br_taken   = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_ready  = 1'b0;
  endtask

  initial begin
    int n;
    rst          = 1'b0;
    bus.halt_req = 1'b0;
    idle();
    model_reset();
    #1;
    check_now();

    // Reset low for three cycles, then bubble fill.
    repeat (3) step();
    rst = 1'b1;
    repeat (INIT_CYC) step();
    chk("run_pc_en", 32'(bus.pc_en), 32'd1);
    repeat (2) step();

    // Load-use stall, then same pattern on r0.
    bus.ex_memread = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8;
    step();
    chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    bus.ex_rt = 5'd0; bus.id_rs = 5'd0;
    step();
    chk("r0_no_stall", 32'(bus.stall_cnt), 32'd1);
    idle();
    step();

    // Branch wins over a load-use match.
    bus.ex_memread = 1'b1; bus.ex_rt = 5'd9; bus.id_rt = 5'd9; bus.br_taken = 1'b1;
    step();
    chk("br_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    idle();

    // Twenty-cycle memory freeze.
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) chk("timeout_early", 32'(bus.mem_timeout), 32'd0);
      step();
    end
    chk("timeout_set", 32'(bus.mem_timeout), 32'd1);
    bus.mem_ready = 1'b1;
    step();
    chk("timeout_sticky", 32'(bus.mem_timeout), 32'd1);
    chk("freeze_stalls", 32'(bus.stall_cnt), 32'd21);
    idle();
    step();

    // Halt with one hazard and one freeze cycle inside the drain.
    bus.halt_req = 1'b1;
    step();
    bus.ex_memread = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5;
    step();
    idle();
    bus.mem_req = 1'b1;
    step();
    idle();
    n = 0;
    while (!bus.halt_ack && n < 10) begin
      step();
      n++;
    end
    chk("drain_cycles", 32'(n + 2), 32'd6);
    chk("halted_pc_en", 32'(bus.pc_en), 32'd0);
    step();
    bus.halt_req = 1'b0;
    step();
    chk("resume_ack", 32'(bus.halt_ack), 32'd0);
    step();

    // Reset while halted.
    bus.halt_req = 1'b1;
    step();
    n = 0;
    while (!bus.halt_ack && n < 10) begin
      step();
      n++;
    end
    chk("halt_again", 32'(bus.halt_ack), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_ack", 32'(bus.halt_ack), 32'd0);
    chk("rst_timeout", 32'(bus.mem_timeout), 32'd0);
    check_now();
    @(posedge clk);
    #1;
    bus.halt_req = 1'b0;
    step();
    rst = 1'b1;
    repeat (INIT_CYC + 1) step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bus.mem_req    = ($urandom_range(0, 3) == 0);
      bus.mem_ready  = ($urandom_range(0, 2) != 0);
      bus.br_taken   = ($urandom_range(0, 7) == 0);
      bus.ex_memread = ($urandom_range(0, 1) == 1);
      bus.ex_rt      = 5'($urandom_range(0, 3));
      bus.id_rs      = 5'($urandom_range(0, 3));
      bus.id_rt      = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) bus.halt_req = ~bus.halt_req;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It drives the load-enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB buffers. It resolves load-use stalls, taken-branch flushes and data-memory wait freezes, and runs a post-reset bubble fill and a debug halt/drain handshake. It sits beside the datapath and owns no data bits; all decisions are taken from stage-resident control fields.

## Interface
- INIT_CYC, 4: bubble-fill cycles after reset release.
- DRAIN_CYC, 4: pipeline-advance cycles needed to retire all in-flight instructions before halt.
- MAX_WAIT, 15: consecutive memory-freeze cycles at which mem_timeout is set; 4-bit wait counter.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  5  source register numbers of the instruction in ID.
- ex_memread  in  1  instruction in EX is a load.
- ex_rt  in  5  destination register of the instruction in EX.
- br_taken  in  1  branch in EX resolved taken this cycle.
- mem_req  in  1  instruction in MEM accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- halt_req  in  1  debug halt request; level, held until release.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables.
- ifid_flush, idex_flush  out  1 each  load a bubble (all-zero control) instead of data; effective only when the matching _en is 1.
- halt_ack  out  1  pipeline empty and frozen.
- mem_timeout  out  1  sticky memory-wait error.
- stall_cnt  out  16  saturating count of RUN-state cycles with pc_en=0.

## Operation
- States: INIT, RUN, DRAIN, HALTED. Enables and flushes are combinational from state and inputs. Counters and state are registered.
- Conditions, in priority order:
  - F = mem_req & ~mem_ready.
  - B = br_taken.
  - H = ex_memread & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
- Per-condition outputs (RUN and DRAIN):
  - F: all enables 0, flushes 0; the whole pipe is frozen.
  - else B: all enables 1, ifid_flush=1, idex_flush=1; H is ignored.
  - else H: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1; exmem_en and memwb_en are 1.
  - else: all enables 1, flushes 0.
- INIT:
  - Outputs: pc_en=0, other enables 1, ifid_flush=1, idex_flush=1.
  - init counter counts 0..INIT_CYC-1, then goes to RUN. F, B and H are ignored.
- RUN: applies the rules above. If halt_req=1 and neither F nor B holds, go to DRAIN with the drain counter at 0.
- DRAIN:
  - Same rules, with these overrides in the no-condition and H cases: pc_en=0 and ifid_flush=1. Under H, ifid_en stays 0 and ifid_flush is 0, so the ID instruction is held.
  - Under B, pc_en=1 so the branch target is captured for resume.
  - The drain counter advances only on cycles without F and without H.
  - When the counter reaches DRAIN_CYC-1 on an advancing cycle, go to HALTED.
  - halt_req dropping in DRAIN has no effect; the drain completes.
- HALTED: all enables 0, halt_ack=1. When halt_req=0, go to RUN; halt_ack is 0 from that edge.
- wait_cnt:
  - Increments on each F cycle, in any state except INIT and HALTED, saturating at MAX_WAIT. Cleared on any non-F cycle.
  - When wait_cnt == MAX_WAIT while F is still 1, mem_timeout sets and stays 1 until reset. The freeze continues until mem_ready.
- stall_cnt increments on each RUN cycle with pc_en=0 and saturates at 0xFFFF.

## Timing
- Reset asserted:
  - state INIT, all counters 0.
  - Outputs: pc_en=0, ifid_en=idex_en=exmem_en=memwb_en=1, ifid_flush=idex_flush=1, halt_ack=0, mem_timeout=0, stall_cnt=0.
- Reset asserted mid-operation aborts DRAIN or HALTED immediately (asynchronously).
- Stall and flush responses are zero-latency (same cycle). State changes take effect on the next rising edge.
- A load-use stall lasts exactly one cycle: the load moves to MEM, so H drops.
- When F and B coincide, the freeze wins. B is held by the frozen EX stage and applies on the first cycle with mem_ready.
- halt_ack rises exactly DRAIN_CYC advancing cycles after DRAIN entry. It is never asserted while any enable is 1.

## Test plan
- Reset low 3 cycles, then released, no other activity -> pc_en=0 with both flushes 1 for 4 cycles; RUN from cycle 5 with all enables 1.
- ex_memread=1, ex_rt=8, id_rs=8 for one cycle -> pc_en=ifid_en=0 and idex_flush=1 that cycle; stall_cnt=1. Repeat with ex_rt=0 -> no stall.
- br_taken=1 together with an H match -> both flushes 1, pc_en=1, stall_cnt unchanged.
- mem_req=1, mem_ready=0 for 20 cycles -> all enables 0 for all 20 cycles; mem_timeout=1 from the 16th freeze cycle and still 1 after mem_ready.
- halt_req=1 in RUN, one H cycle and one F cycle during DRAIN -> halt_ack after 6 cycles, enables all 0; halt_req=0 -> RUN next edge, halt_ack=0.
- Reset asserted while HALTED -> immediate reset values, then INIT sequence again.
